// File: rtl/fb_sink_pkg.sv
// Shared types and helpers for the framebuffer stream sink: FSM states,
// FIFO word layout, raster totals and RGB555 -> RGB888 expansion.
package fb_sink_pkg;

    typedef enum logic [1:0] {SEEK, PRIME, RUN} sink_state_e;

    localparam int R_LSB = 10;
    localparam int G_LSB = 5;
    localparam int B_LSB = 0;

    typedef struct packed {
        logic        start;
        logic [14:0] data;
    } fb_word_t;

    function automatic int h_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    // Replicating the top bits maps 0 -> 0x00 and full scale -> 0xFF.
    function automatic logic [7:0] expand5to8(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

endpackage

// File: rtl/fb_sink_fifo.sv
// Small synchronous FIFO; flush wins over push/pop, push on a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module fb_sink_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fb_stream_sink.sv
// Framebuffer stream sink: buffers RGB555 words, runs raster timing and
// emits registered RGB888 + DE/HS/VS, resyncing on stream/timing mismatch.
module fb_stream_sink
    import fb_sink_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        iCLK,
    input  logic        iRESET,
    input  logic        iFB_START,
    input  logic [14:0] iFB_DATA,
    input  logic        iFB_DATAVALID,
    output logic        oFB_READY,
    output logic [7:0]  oRED,
    output logic [7:0]  oGRN,
    output logic [7:0]  oBLU,
    output logic        oDE,
    output logic        oHS,
    output logic        oVS,
    output logic        oUNDERRUN,
    output logic        oRESYNC
);
    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_BEG_C = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END_C = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_BEG_C = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END_C = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] hcnt_q;
    logic [VW-1:0] vcnt_q;
    sink_state_e   state_q, state_d;
    logic          rdy_en_q;
    logic [7:0]    red_q, grn_q, blu_q;
    logic          de_q, hs_q, vs_q, und_q, rsync_q;

    logic     h_last, v_last, active, hs_act, vs_act, frame_first, frame_last;
    logic     xfer, push, pop, flush, resync, underrun, pix_ok;
    logic     full, empty;
    fb_word_t head, wr_word;

    assign h_last      = (hcnt_q == H_LAST_C);
    assign v_last      = (vcnt_q == V_LAST_C);
    assign active      = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
    assign hs_act      = (hcnt_q >= HS_BEG_C) && (hcnt_q < HS_END_C);
    assign vs_act      = (vcnt_q >= VS_BEG_C) && (vcnt_q < VS_END_C);
    assign frame_first = (hcnt_q == '0) && (vcnt_q == '0);
    assign frame_last  = h_last && v_last;

    // Held low for the first cycle after reset so READY reads 0 in reset.
    assign oFB_READY = rdy_en_q && ((state_q == SEEK) || !full);
    assign xfer      = iFB_DATAVALID && oFB_READY;
    assign wr_word   = '{start: iFB_START, data: iFB_DATA};

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else if (h_last) begin
            hcnt_q <= '0;
            vcnt_q <= v_last ? '0 : vcnt_q + VW'(1);
        end else begin
            hcnt_q <= hcnt_q + HW'(1);
        end
    end

    fb_sink_fifo #(
        .WIDTH ($bits(fb_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (iCLK),
        .rst_i   (iRESET),
        .push_i  (push),
        .wdata_i (wr_word),
        .pop_i   (pop),
        .flush_i (flush),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        pop      = 1'b0;
        flush    = 1'b0;
        resync   = 1'b0;
        underrun = 1'b0;
        pix_ok   = 1'b0;
        unique case (state_q)
            SEEK: begin
                // Everything ahead of a frame start is swallowed.
                if (xfer && iFB_START) begin
                    push    = 1'b1;
                    state_d = PRIME;
                end
            end
            PRIME: begin
                push = xfer;
                if (frame_last) state_d = RUN;
            end
            RUN: begin
                push = xfer;
                if (active) begin
                    if (empty) begin
                        underrun = 1'b1;
                        resync   = 1'b1;
                    end else begin
                        pop = 1'b1;
                        if (head.start != frame_first) resync = 1'b1;
                        else                           pix_ok = 1'b1;
                    end
                end
                if (resync) begin
                    flush   = 1'b1;
                    state_d = SEEK;
                end
            end
            default: state_d = SEEK;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_q  <= SEEK;
            rdy_en_q <= 1'b0;
            red_q    <= '0;
            grn_q    <= '0;
            blu_q    <= '0;
            de_q     <= 1'b0;
            hs_q     <= ~SYNC_POL;
            vs_q     <= ~SYNC_POL;
            und_q    <= 1'b0;
            rsync_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            red_q    <= pix_ok ? expand5to8(head.data[R_LSB +: 5]) : 8'h00;
            grn_q    <= pix_ok ? expand5to8(head.data[G_LSB +: 5]) : 8'h00;
            blu_q    <= pix_ok ? expand5to8(head.data[B_LSB +: 5]) : 8'h00;
            de_q     <= active;
            hs_q     <= hs_act ? SYNC_POL : ~SYNC_POL;
            vs_q     <= vs_act ? SYNC_POL : ~SYNC_POL;
            und_q    <= und_q | underrun;
            rsync_q  <= resync;
        end
    end

    assign oRED      = red_q;
    assign oGRN      = grn_q;
    assign oBLU      = blu_q;
    assign oDE       = de_q;
    assign oHS       = hs_q;
    assign oVS       = vs_q;
    assign oUNDERRUN = und_q;
    assign oRESYNC   = rsync_q;

endmodule

// File: tb/tb_fb_stream_sink.sv
// Directed bench for fb_stream_sink on a shrunken 40x4 raster (47x8 total)
// so every scenario fits in a handful of frames.
module tb_fb_stream_sink;
    localparam int HA = 40, HFP = 2, HSY = 3, HBP = 2;
    localparam int VA = 4,  VFP = 1, VSY = 2, VBP = 1;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FW = HA * VA;
    localparam logic [28:0] RST_V = {1'b0, 1'b1, 1'b1, 24'h0, 2'b00};

    logic        clk = 1'b0;
    logic        rst, start, valid, ready;
    logic [14:0] data;
    logic [7:0]  red, grn, blu;
    logic        de, hs, vs, und, rsy;

    always #5 clk = ~clk;

    fb_stream_sink #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
        .SYNC_POL (1'b0), .FIFO_DEPTH (16)
    ) dut (
        .iCLK (clk), .iRESET (rst), .iFB_START (start), .iFB_DATA (data),
        .iFB_DATAVALID (valid), .oFB_READY (ready),
        .oRED (red), .oGRN (grn), .oBLU (blu),
        .oDE (de), .oHS (hs), .oVS (vs), .oUNDERRUN (und), .oRESYNC (rsy)
    );

    int errs = 0, checks = 0;
    int th, tv, ph, pv, w;
    bit src_en, gap, inj, exp_on, exp_rs, exp_und;
    logic [28:0] exp_prev;
    int acc_cnt, rs_cnt, n_de, n_hs, n_vs;

    function automatic logic [7:0] x8(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    // Expected registered outputs for raster position (h,v); pixel data is
    // R = x, G = y, B = ~x, all 5-bit.
    function automatic logic [28:0] expv(input int h, input int v, input bit on,
                                         input bit u, input bit r);
        logic d, hsl, vsl;
        logic [4:0] r5, g5;
        logic [23:0] rgb;
        d   = (h < HA) && (v < VA);
        hsl = !((h >= HA + HFP) && (h < HA + HFP + HSY));
        vsl = !((v >= VA + VFP) && (v < VA + VFP + VSY));
        r5  = 5'(h);
        g5  = 5'(v);
        rgb = (on && d) ? {x8(r5), x8(g5), x8(~r5)} : 24'h0;
        return {d, hsl, vsl, rgb, u, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One pixel clock: drive the source, check last edge's outputs, advance.
    task automatic cyc();
        logic xf;
        logic [4:0] wx, wy;
        wx    = 5'(w % HA);
        wy    = 5'(w / HA);
        valid = src_en && !gap;
        start = (w == 0) || (inj && w == 100);
        data  = {wx, wy, ~wx};
        @(negedge clk);
        chk($sformatf("pix@%0d,%0d", ph, pv), {de, hs, vs, red, grn, blu, und, rsy}, exp_prev);
        if (rsy) rs_cnt++;
        if (de)  n_de++;
        if (!hs) n_hs++;
        if (!vs) n_vs++;
        xf       = valid && ready;
        exp_prev = expv(th, tv, exp_on, exp_und, exp_rs);
        ph = th;
        pv = tv;
        @(posedge clk);
        #1;
        if (xf) begin
            acc_cnt++;
            if (inj && w == 100) inj = 1'b0;
            w = (w + 1) % FW;
        end
        if (th == HT - 1) begin
            th = 0;
            tv = (tv == VT - 1) ? 0 : tv + 1;
        end else begin
            th++;
        end
    endtask

    task automatic run_to(input int h, input int v);
        while (th != h || tv != v) cyc();
    endtask

    task automatic run_frames(input int n);
        repeat (n) begin
            cyc();
            run_to(0, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0; data = '0;
        src_en = 0; gap = 0; inj = 0; exp_on = 0; exp_rs = 0; exp_und = 0;
        w = 0; acc_cnt = 0; rs_cnt = 0; n_de = 0; n_hs = 0; n_vs = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {de, hs, vs, red, grn, blu, und, rsy}, RST_V);
        chk("reset_ready", ready, 0);
        rst = 1'b0;
        th = 0; tv = 0; ph = -1; pv = -1;
        exp_prev = RST_V;

        // Timing only, no stream
        run_frames(1);
        chk("de_cycles", n_de, 160);
        chk("hs_cycles", n_hs, 24);
        chk("vs_cycles", n_vs, 94);
        chk("idle_resync", rs_cnt, 0);
        chk("idle_underrun", und, 0);

        // Start streaming mid-frame: SEEK takes the start word, PRIME fills
        repeat (50) cyc();
        src_en = 1; acc_cnt = 0;
        run_to(HT - 1, VT - 1);
        chk("prime_full_ready", ready, 0);
        chk("prime_words", acc_cnt, 16);
        cyc();
        exp_on = 1; rs_cnt = 0;
        cyc();
        chk("red_x0", red, 8'h00);
        chk("blu_x0", blu, 8'hFF);
        run_to(16, 0); cyc();
        chk("red_x16", red, 8'h84);
        chk("blu_x16", blu, 8'h7B);
        run_to(31, 3); cyc();
        chk("red_x31", red, 8'hFF);
        chk("grn_y3", grn, 8'h18);
        chk("blu_x31", blu, 8'h00);
        run_to(0, 0);
        run_frames(2);
        chk("stream_no_resync", rs_cnt, 0);

        // 20-cycle source gap from (10,1): FIFO holds 15, runs dry at (25,1)
        run_to(10, 1);
        gap = 1;
        repeat (15) cyc();
        exp_on = 0; exp_rs = 1; exp_und = 1;
        cyc();
        exp_rs = 0;
        repeat (4) cyc();
        gap = 0;
        run_to(0, 0);
        chk("underrun_resyncs", rs_cnt, 1);
        chk("underrun_sticky", und, 1);
        exp_on = 1; rs_cnt = 0;
        run_frames(1);
        chk("underrun_relock", rs_cnt, 0);

        // Stray START on word (20,2)
        inj = 1;
        run_to(20, 2);
        exp_on = 0; exp_rs = 1;
        cyc();
        exp_rs = 0;
        chk("stray_seek_ready", ready, 1);
        run_to(0, 0);
        chk("stray_resyncs", rs_cnt, 1);
        exp_on = 1; rs_cnt = 0;
        run_frames(1);
        chk("stray_relock", rs_cnt, 0);

        // Asynchronous reset mid-frame
        run_to(30, 2);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs", {de, hs, vs, red, grn, blu, und, rsy}, RST_V);
        chk("async_reset_ready", ready, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        th = 0; tv = 0; ph = -1; pv = -1;
        exp_prev = RST_V; exp_on = 0; exp_und = 0; rs_cnt = 0;
        run_frames(1);
        exp_on = 1;
        run_frames(1);
        chk("reset_relock", rs_cnt, 0);
        chk("reset_underrun_clear", und, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
